// File: rtl/mem_uart_send_sequencer.sv
// mem_uart_send_sequencer: streams a character block from ROM or RAM into the UART TX FIFO,
// ending on length, terminator or abort and holding off while the FIFO is full.
module mem_uart_send_sequencer #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 7,
   parameter int MEM_LATENCY = 1,
   parameter logic [DATA_BITS-1:0] TERMINATOR = '0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 source_sel,
   input  logic [ADDR_BITS-1:0] start_addr,
   input  logic [ADDR_BITS:0]   length,
   input  logic                 tx_full,
   input  logic [DATA_BITS-1:0] mem_data,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic                 mem_sel,
   output logic [7:0]           tx_data,
   output logic                 write_to_uart,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic [ADDR_BITS:0]   char_count
);
   typedef enum logic [2:0] {IDLE, WAIT, PUSH, ADVANCE, DONE} state_t;
   localparam logic [1:0] LAT = 2'(MEM_LATENCY);
   state_t state, next_state;
   logic [ADDR_BITS:0] len_q, len_d, char_count_d;
   logic [ADDR_BITS-1:0] mem_addr_d;
   logic [1:0] lat, lat_d;
   logic [7:0] tx_data_d;
   logic mem_sel_d, write_d, busy_d, done_d, aborted_d;
   logic accept, load, expire, last, term;
   assign accept = state == IDLE && start && !abort;
   assign load = accept && length != '0;
   assign expire = state == WAIT && lat == 2'd1;
   assign last = char_count + 1'b1 == len_q;
   assign term = mem_data == TERMINATOR;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         len_q <= '0;
         lat <= '0;
         mem_addr <= '0;
         mem_sel <= 1'b0;
         tx_data <= '0;
         write_to_uart <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         aborted <= 1'b0;
         char_count <= '0;
      end else begin
         state <= next_state;
         len_q <= len_d;
         lat <= lat_d;
         mem_addr <= mem_addr_d;
         mem_sel <= mem_sel_d;
         tx_data <= tx_data_d;
         write_to_uart <= write_d;
         busy <= busy_d;
         done <= done_d;
         aborted <= aborted_d;
         char_count <= char_count_d;
      end
   end
   // abort takes priority over a data capture landing on the same edge
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = accept ? (length == '0 ? DONE : WAIT) : IDLE;
         WAIT:    next_state = abort ? DONE : expire ? (term ? DONE : PUSH) : WAIT;
         PUSH:    next_state = abort ? DONE : tx_full ? PUSH : ADVANCE;
         ADVANCE: next_state = (abort || last) ? DONE : WAIT;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end
   always_comb begin
      len_d = load ? length : len_q;
      mem_sel_d = load ? source_sel : mem_sel;
      mem_addr_d = load ? start_addr
                 : (state == ADVANCE && next_state == WAIT) ? mem_addr + 1'b1 : mem_addr;
      lat_d = (state != WAIT && next_state == WAIT) ? LAT : state == WAIT ? lat - 2'd1 : lat;
      tx_data_d = (expire && !abort && !term) ? 8'(mem_data) : tx_data;
      write_d = state == PUSH && !abort && !tx_full;
      char_count_d = accept ? '0 : state == ADVANCE ? char_count + 1'b1 : char_count;
      busy_d = accept ? 1'b1 : state == DONE ? 1'b0 : busy;
      done_d = state == DONE;
      aborted_d = accept ? 1'b0
                : (abort && (state == WAIT || state == PUSH || state == ADVANCE)) ? 1'b1 : aborted;
   end
endmodule
